text_overlay_scheduler: RTL and testbench
=========================================

Name: text_overlay_scheduler

Overview:
- Shares one on-screen text line (NUM_CHARS glyph cells) between two message producers, e.g. the door-status and temperature tasks.
- Round-robin arbitration; characters go into a shadow buffer. A complete message commits to the active buffer only on a frame boundary, so the display never tears.
- Per pixel, drives the current cell's character code and cell origin to the downstream text-cell/glyph stage.

Parameters:
- NUM_CHARS, 8, character cells on the line (power of two, max 16)
- X_ORIGIN, 10'd64, left pixel of cell 0
- Y_ORIGIN, 10'd32, top pixel of the line
- CHAR_W, 16, cell width in pixels (fixed: index = (x-X_ORIGIN)>>4)
- CHAR_H, 32, cell height in pixels

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse at the start of each frame (x=0,y=0)
- x  in  10  current pixel column
- y  in  10  current pixel row
- req  in  2  per-writer request; held for the whole message
- char_valid  in  2  per-writer character strobe
- char_data  in  14  writer1 on [13:7], writer0 on [6:0], 7-bit ASCII
- char_last  in  2  marks a writer's final character
- grant  out  2  one-hot; only the granted writer's char_valid is honoured
- busy  out  1  high from grant until the message commits or is aborted
- ascii_out  out  7  character code for the current cell
- x_desired  out  10  left pixel of the current cell
- y_desired  out  10  equals Y_ORIGIN
- in_line  out  1  the pixel lies inside the text line

Behaviour:
- Reset: grant=0, busy=0, ascii_out=0, x_desired=X_ORIGIN, y_desired=Y_ORIGIN, in_line=0. Active and shadow buffers become all 7'h20 (space). Round-robin pointer set to favour writer0. Pending flag cleared. Reset mid-message discards it.
- FSM states: IDLE, WRITE, COMMIT_WAIT.
- IDLE:
  - If any req bit is set, grant one writer: the non-last-served writer if both request, otherwise the sole requester.
  - Load the shadow buffer with all spaces, set index=0, go to WRITE.
  - grant and busy assert on the cycle after req is sampled.
- WRITE:
  - Each cycle with char_valid of the granted writer: shadow[index] <= char_data, index++.
  - index >= NUM_CHARS: character is silently dropped, index saturates, no error.
  - char_valid together with char_last: store the character (if room), set pending, deassert grant, go to COMMIT_WAIT, and mark this writer last-served.
  - Granted req drops before char_last: abort. Shadow discarded, no commit, back to IDLE. The aborted writer still counts as last-served.
  - The other writer's inputs are ignored.
- COMMIT_WAIT:
  - busy stays high; no grants.
  - On frame_start, copy shadow to active in one cycle, clear pending, go to IDLE.
  - A frame_start in the same cycle as the char_last accept does not commit; commit happens at the next frame_start.
- Display path, one-cycle registered latency; downstream must delay x/y by one cycle to match:
  - in_line = (x >= X_ORIGIN) && (x < X_ORIGIN + NUM_CHARS*16) && (y >= Y_ORIGIN) && (y < Y_ORIGIN + CHAR_H).
  - idx = (x - X_ORIGIN) >> 4, in 10-bit arithmetic, evaluated only when in_line.
  - When in_line: ascii_out = active[idx], x_desired = X_ORIGIN + (idx << 4).
  - Otherwise ascii_out = 0 and x_desired holds its last value.
  - The active buffer changes only at frame_start, so the display reads stable data for the whole frame.

Test Plan:
- Reset, then scan row y=40: pixels x=64..191 give in_line=1 and ascii_out=7'h20 one cycle later. x=63 and x=192 give in_line=0. x=80 gives x_desired=80.
- Writer0 sends "DOOR" with last on 'R', then frame_start: active = "DOOR" plus 4 spaces. Pixel (x=100,y=40) gives ascii_out='O' (7'h4F), x_desired=96. Before frame_start, the previous content is still displayed.
- Both req set in the same cycle from reset: writer0 is granted first. After writer0 commits, writer1 is granted next, even if writer0 re-requests at once.
- Writer1 sends 10 characters "TEMP=23.5C" (NUM_CHARS=8): active = "TEMP=23." and the last two are dropped. grant releases after char_last.
- Writer0 sends "AB" then drops req without char_last: back to IDLE, busy=0, active unchanged across the next frame_start, and writer1 is granted next.
- char_last accepted in the same cycle as frame_start: no update in that frame. Commit happens at the following frame_start. Assert reset during COMMIT_WAIT: active stays all spaces, busy=0.

Source files
------------

// File: rtl/text_overlay_scheduler.sv
// text_overlay_scheduler
// Two message writers share one on-screen text line of NUM_CHARS glyph cells.
// A round-robin arbiter grants one writer at a time. Its characters fill a
// shadow buffer, and a finished message is copied to the active buffer only at
// frame_start, so a frame never shows a half-written line. The display path
// registers, for every pixel, the character code and the cell origin of the
// cell under (x, y).
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high
//   frame_start  one-cycle pulse at pixel (0,0) of each frame
//   x, y         current pixel column / row
//   req          per-writer request, held for the whole message
//   char_valid   per-writer character strobe
//   char_data    writer1 on [13:7], writer0 on [6:0] (7-bit ASCII)
//   char_last    per-writer final-character marker
//   grant        one-hot grant to the writer currently being served
//   busy         high from grant until the message commits or aborts
//   ascii_out    character code of the current cell (0 outside the line)
//   x_desired    left pixel of the current cell (holds outside the line)
//   y_desired    top pixel of the line
//   in_line      pixel lies inside the text line
module text_overlay_scheduler #(
    parameter int unsigned NUM_CHARS = 8,
    parameter logic [9:0]  X_ORIGIN  = 10'd64,
    parameter logic [9:0]  Y_ORIGIN  = 10'd32,
    parameter int unsigned CHAR_W    = 16,
    parameter int unsigned CHAR_H    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [1:0]  req,
    input  logic [1:0]  char_valid,
    input  logic [13:0] char_data,
    input  logic [1:0]  char_last,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [6:0]  ascii_out,
    output logic [9:0]  x_desired,
    output logic [9:0]  y_desired,
    output logic        in_line
);

    localparam int unsigned IDX_W      = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam logic [IDX_W:0] FULL    = (IDX_W + 1)'(NUM_CHARS);
    localparam logic [9:0]  LINE_X_END = X_ORIGIN + 10'(NUM_CHARS * CHAR_W);
    localparam logic [9:0]  LINE_Y_END = Y_ORIGIN + 10'(CHAR_H);
    localparam logic [6:0]  SPACE      = 7'h20;

    typedef enum logic [1:0] {StIdle, StWrite, StCommitWait} state_t;

    state_t         state;
    logic [6:0]     shadow [NUM_CHARS];
    logic [6:0]     active [NUM_CHARS];
    // One extra bit so the index can sit at NUM_CHARS once the line is full.
    logic [IDX_W:0] index;
    logic           cur;          // writer being served
    logic           last_served;  // writer that most recently held the line
    logic           pending;      // shadow holds a complete message awaiting commit

    // Selected writer's view of the shared inputs.
    logic       pick;
    logic       wr_req;
    logic       wr_valid;
    logic       wr_last;
    logic [6:0] wr_char;

    // With both requesting, the writer not served last wins; otherwise the sole requester.
    assign pick     = (&req) ? ~last_served : req[1];
    assign wr_req   = req[cur];
    assign wr_valid = char_valid[cur];
    assign wr_last  = char_last[cur];
    assign wr_char  = cur ? char_data[13:7] : char_data[6:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            grant       <= 2'b00;
            busy        <= 1'b0;
            cur         <= 1'b0;
            last_served <= 1'b1;
            pending     <= 1'b0;
            index       <= '0;
            for (int i = 0; i < NUM_CHARS; i++) begin
                shadow[i] <= SPACE;
                active[i] <= SPACE;
            end
        end else begin
            unique case (state)
                StIdle: begin
                    if (|req) begin
                        cur   <= pick;
                        grant <= pick ? 2'b10 : 2'b01;
                        busy  <= 1'b1;
                        index <= '0;
                        for (int i = 0; i < NUM_CHARS; i++) begin
                            shadow[i] <= SPACE;
                        end
                        state <= StWrite;
                    end
                end
                StWrite: begin
                    if (!wr_req) begin
                        // Abort: shadow content is simply never committed.
                        grant       <= 2'b00;
                        busy        <= 1'b0;
                        last_served <= cur;
                        state       <= StIdle;
                    end else if (wr_valid) begin
                        if (index < FULL) begin
                            shadow[index[IDX_W-1:0]] <= wr_char;
                            index                    <= index + 1'b1;
                        end
                        if (wr_last) begin
                            pending     <= 1'b1;
                            grant       <= 2'b00;
                            last_served <= cur;
                            state       <= StCommitWait;
                        end
                    end
                end
                StCommitWait: begin
                    if (frame_start && pending) begin
                        for (int i = 0; i < NUM_CHARS; i++) begin
                            active[i] <= shadow[i];
                        end
                        pending <= 1'b0;
                        busy    <= 1'b0;
                        state   <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Display path: one cycle from (x, y) to the registered cell outputs.
    logic       in_line_c;
    logic [9:0] idx_full;
    logic [IDX_W-1:0] idx;

    assign in_line_c = (x >= X_ORIGIN) && (x < LINE_X_END) &&
                       (y >= Y_ORIGIN) && (y < LINE_Y_END);
    assign idx_full  = (x - X_ORIGIN) >> 4;
    assign idx       = idx_full[IDX_W-1:0];
    assign y_desired = Y_ORIGIN;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_line   <= 1'b0;
            ascii_out <= 7'h00;
            x_desired <= X_ORIGIN;
        end else begin
            in_line <= in_line_c;
            if (in_line_c) begin
                ascii_out <= active[idx];
                x_desired <= X_ORIGIN + (idx_full << 4);
            end else begin
                ascii_out <= 7'h00;
            end
        end
    end

endmodule

// File: tb/tb_text_overlay_scheduler.sv
// Self-checking bench for text_overlay_scheduler: pixel lookups go through a
// one-deep scoreboard, arbitration and commit timing are checked by hand-written
// sequences.
module tb_text_overlay_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [1:0]  req = '0;
    logic [1:0]  char_valid = '0;
    logic [13:0] char_data = '0;
    logic [1:0]  char_last = '0;
    logic [1:0]  grant;
    logic        busy;
    logic [6:0]  ascii_out;
    logic [9:0]  x_desired;
    logic [9:0]  y_desired;
    logic        in_line;

    text_overlay_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .x           (x),
        .y           (y),
        .req         (req),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_last   (char_last),
        .grant       (grant),
        .busy        (busy),
        .ascii_out   (ascii_out),
        .x_desired   (x_desired),
        .y_desired   (y_desired),
        .in_line     (in_line)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ein;
        logic [6:0] ea;
        logic [9:0] ex;
        bit         cx;
        string      tag;
    } exp_t;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic       ein;
        logic [6:0] ea;
        logic [9:0] ex;
        bit         cx;
    } vec_t;

    exp_t       sb[$];
    vec_t       tbl[10];
    logic [6:0] model_active [8];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one pixel, queue its expectation, and compare once the output register updates.
    task automatic pix(input logic [9:0] px, input logic [9:0] py, input exp_t e);
        exp_t got;
        x = px;
        y = py;
        sb.push_back(e);
        step();
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", e.tag);
        end else begin
            got = sb.pop_front();
            chk({got.tag, ".in_line"}, 32'(in_line), 32'(got.ein));
            chk({got.tag, ".ascii_out"}, 32'(ascii_out), 32'(got.ea));
            if (got.cx) chk({got.tag, ".x_desired"}, 32'(x_desired), 32'(got.ex));
        end
    endtask

    task automatic run_tbl(input int lo, input int hi, input string tag);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            e.ein = tbl[i].ein;
            e.ea  = tbl[i].ea;
            e.ex  = tbl[i].ex;
            e.cx  = tbl[i].cx;
            e.tag = $sformatf("%s[%0d]", tag, i);
            pix(tbl[i].px, tbl[i].py, e);
        end
    endtask

    task automatic set_model(input string s);
        byte b;
        for (int i = 0; i < 8; i++) begin
            if (i < s.len()) begin
                b = s[i];
                model_active[i] = b[6:0];
            end else begin
                model_active[i] = 7'h20;
            end
        end
    endtask

    // Probe every cell of the line at an off-origin pixel inside the cell.
    task automatic check_line(input string tag);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.ein = 1'b1;
            e.ea  = model_active[i];
            e.ex  = 10'(64 + 16 * i);
            e.cx  = 1'b1;
            e.tag = $sformatf("%s.cell%0d", tag, i);
            pix(10'(64 + 16 * i + 7), 10'd40, e);
        end
    endtask

    task automatic send(input int w, input string s, input bit with_last,
                        input bit fs_on_last, input bit junk);
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            char_valid = '0;
            char_last  = '0;
            char_data  = '0;
            char_valid[w] = 1'b1;
            if (w == 1) char_data[13:7] = c[6:0];
            else        char_data[6:0]  = c[6:0];
            if (junk) begin
                // The ungranted writer strobes 'Z' with last; it must have no effect.
                char_valid[1-w] = 1'b1;
                char_last[1-w]  = 1'b1;
                if (w == 1) char_data[6:0]  = 7'h5A;
                else        char_data[13:7] = 7'h5A;
            end
            if (with_last && i == s.len() - 1) begin
                char_last[w] = 1'b1;
                frame_start  = fs_on_last;
            end
            step();
        end
        char_valid  = '0;
        char_last   = '0;
        char_data   = '0;
        frame_start = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        set_model("");
    endtask

    initial begin
        exp_t e;

        // Boundary pixels: in_line edges on both axes and cell origin lookups.
        tbl[0] = '{10'd63,  10'd40, 1'b0, 7'h00, 10'd0,   1'b0};
        tbl[1] = '{10'd192, 10'd40, 1'b0, 7'h00, 10'd0,   1'b0};
        tbl[2] = '{10'd80,  10'd40, 1'b1, 7'h20, 10'd80,  1'b1};
        tbl[3] = '{10'd100, 10'd31, 1'b0, 7'h00, 10'd0,   1'b0};
        tbl[4] = '{10'd100, 10'd64, 1'b0, 7'h00, 10'd0,   1'b0};
        tbl[5] = '{10'd191, 10'd63, 1'b1, 7'h20, 10'd176, 1'b1};
        // After "DOOR" commits.
        tbl[6] = '{10'd100, 10'd40, 1'b1, 7'h4F, 10'd96,  1'b1};
        tbl[7] = '{10'd64,  10'd40, 1'b1, 7'h44, 10'd64,  1'b1};
        tbl[8] = '{10'd127, 10'd40, 1'b1, 7'h52, 10'd112, 1'b1};
        tbl[9] = '{10'd128, 10'd40, 1'b1, 7'h20, 10'd128, 1'b1};

        do_reset();
        chk("reset.grant", 32'(grant), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.ascii_out", 32'(ascii_out), 32'd0);
        chk("reset.x_desired", 32'(x_desired), 32'd64);
        chk("reset.y_desired", 32'(y_desired), 32'd32);
        chk("reset.in_line", 32'(in_line), 32'd0);

        // Full scan of row 40 after reset.
        for (int px = 64; px <= 191; px++) begin
            e.ein = 1'b1;
            e.ea  = 7'h20;
            e.ex  = 10'(64 + ((px - 64) / 16) * 16);
            e.cx  = 1'b1;
            e.tag = $sformatf("scan.x%0d", px);
            pix(10'(px), 10'd40, e);
        end
        run_tbl(0, 5, "edge");

        // Writer0 "DOOR": held back until frame_start.
        req = 2'b01;
        step();
        chk("door.grant", 32'(grant), 32'b01);
        chk("door.busy", 32'(busy), 32'd1);
        send(0, "DOOR", 1'b1, 1'b0, 1'b0);
        req = 2'b00;
        chk("door.grant_released", 32'(grant), 32'd0);
        chk("door.busy_wait", 32'(busy), 32'd1);
        e.ein = 1'b1; e.ea = 7'h20; e.ex = 10'd96; e.cx = 1'b1; e.tag = "door.pre_commit";
        pix(10'd100, 10'd40, e);
        pulse_frame();
        chk("door.busy_after_commit", 32'(busy), 32'd0);
        set_model("DOOR");
        run_tbl(6, 9, "door");
        check_line("door");

        // Both request from reset: writer0 first, then writer1 despite writer0 re-requesting.
        do_reset();
        req = 2'b11;
        step();
        chk("rr.first_grant", 32'(grant), 32'b01);
        send(0, "HI", 1'b1, 1'b0, 1'b0);
        chk("rr.hi_released", 32'(grant), 32'd0);
        pulse_frame();
        set_model("HI");
        check_line("hi");
        chk("rr.second_grant", 32'(grant), 32'b10);
        chk("rr.second_busy", 32'(busy), 32'd1);

        // Writer1 overflows the line; the ungranted writer strobes junk throughout.
        send(1, "TEMP=23.5C", 1'b1, 1'b0, 1'b1);
        req = 2'b00;
        chk("temp.grant_released", 32'(grant), 32'd0);
        chk("temp.busy_wait", 32'(busy), 32'd1);
        pulse_frame();
        set_model("TEMP=23.5C");
        check_line("temp");

        // Writer0 aborts: no commit, and writer1 wins the next contested grant.
        req = 2'b01;
        step();
        chk("abort.grant", 32'(grant), 32'b01);
        send(0, "AB", 1'b0, 1'b0, 1'b0);
        req = 2'b00;
        step();
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.grant_off", 32'(grant), 32'd0);
        pulse_frame();
        check_line("abort");
        req = 2'b11;
        step();
        chk("abort.next_grant", 32'(grant), 32'b10);
        req = 2'b00;
        step();
        chk("abort2.busy", 32'(busy), 32'd0);

        // char_last in the same cycle as frame_start: commit waits one frame.
        req = 2'b01;
        step();
        chk("samecyc.grant", 32'(grant), 32'b01);
        send(0, "XY", 1'b1, 1'b1, 1'b0);
        req = 2'b00;
        chk("samecyc.busy", 32'(busy), 32'd1);
        check_line("samecyc.held");
        pulse_frame();
        chk("samecyc.busy_after", 32'(busy), 32'd0);
        set_model("XY");
        check_line("samecyc.commit");

        // Reset while a message waits to commit.
        req = 2'b10;
        step();
        chk("rstcw.grant", 32'(grant), 32'b10);
        send(1, "Q", 1'b1, 1'b0, 1'b0);
        req = 2'b00;
        chk("rstcw.busy_before", 32'(busy), 32'd1);
        do_reset();
        chk("rstcw.busy", 32'(busy), 32'd0);
        chk("rstcw.grant", 32'(grant), 32'd0);
        chk("rstcw.x_desired", 32'(x_desired), 32'd64);
        pulse_frame();
        chk("rstcw.busy_after_frame", 32'(busy), 32'd0);
        check_line("rstcw");

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
